// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter sharing one register between NUM_REQ burst writers.
// Also sequences a deferred global clear and revokes ownership from stalled owners.
module register_write_arbiter #(
    parameter int BITWIDTH = 32,
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic [NUM_REQ-1:0]          iReq,
    input  logic [NUM_REQ-1:0]          iLast,
    input  logic [NUM_REQ*BITWIDTH-1:0] iData,
    input  logic                        iClr,
    output logic [NUM_REQ-1:0]          oGnt,
    output logic                        oBusy,
    output logic                        oEn,
    output logic                        oClr,
    output logic [BITWIDTH-1:0]         oData
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(TIMEOUT + 2);
    localparam logic [SW-1:0] STALL_LAST = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, OWN, CLEAR} state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        ptr_reg, ptr_next;
    logic [IW-1:0]        owner_reg, owner_next;
    logic [SW-1:0]        stall_reg, stall_next;
    logic                 clr_pend_reg, clr_pend_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic                 busy_reg, busy_next;
    logic                 en_reg, en_next;
    logic                 clr_reg, clr_next;
    logic [BITWIDTH-1:0]  data_reg, data_next;

    // Rotate requests so that bit 0 corresponds to ptr, then take the lowest set bit.
    logic [2*NUM_REQ-1:0] req_shift;
    logic [NUM_REQ-1:0]   rot_req;
    logic [IW-1:0]        pick_off;
    logic [IW:0]          pick_sum;
    logic [IW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        owner_inc;
    logic                 beat;

    assign req_shift = {iReq, iReq} >> ptr_reg;
    assign rot_req   = req_shift[NUM_REQ-1:0];

    always_comb begin
        pick_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) pick_off = IW'(i);
        end
    end

    assign pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= (IW+1)'(NUM_REQ)) ? IW'(pick_sum - (IW+1)'(NUM_REQ))
                                                     : IW'(pick_sum);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    assign owner_inc = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
    assign beat      = iReq[owner_reg];

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        stall_next    = stall_reg;
        clr_pend_next = clr_pend_reg | iClr;
        gnt_next      = gnt_reg;
        busy_next     = busy_reg;
        en_next       = 1'b0;
        clr_next      = 1'b0;
        data_next     = data_reg;

        case (state_reg)
            IDLE: begin
                if (clr_pend_reg) begin
                    // A clear arriving on the entry cycle stays pending for another pass.
                    state_next    = CLEAR;
                    clr_next      = 1'b1;
                    busy_next     = 1'b1;
                    clr_pend_next = iClr;
                end else if (|iReq) begin
                    state_next = OWN;
                    owner_next = pick_idx;
                    gnt_next   = pick_onehot;
                    busy_next  = 1'b1;
                    stall_next = '0;
                end
            end
            OWN: begin
                if (beat) begin
                    en_next    = 1'b1;
                    data_next  = iData[int'(owner_reg)*BITWIDTH +: BITWIDTH];
                    stall_next = '0;
                    if (iLast[owner_reg]) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        busy_next  = 1'b0;
                        ptr_next   = owner_inc;
                    end
                end else if (TIMEOUT != 0) begin
                    if (stall_reg == STALL_LAST) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        busy_next  = 1'b0;
                        ptr_next   = owner_inc;
                        stall_next = '0;
                    end else begin
                        stall_next = stall_reg + 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            stall_reg    <= '0;
            clr_pend_reg <= 1'b0;
            gnt_reg      <= '0;
            busy_reg     <= 1'b0;
            en_reg       <= 1'b0;
            clr_reg      <= 1'b0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            stall_reg    <= stall_next;
            clr_pend_reg <= clr_pend_next;
            gnt_reg      <= gnt_next;
            busy_reg     <= busy_next;
            en_reg       <= en_next;
            clr_reg      <= clr_next;
            data_reg     <= data_next;
        end
    end

    assign oGnt  = gnt_reg;
    assign oBusy = busy_reg;
    assign oEn   = en_reg;
    assign oClr  = clr_reg;
    assign oData = data_reg;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed and randomized checks of register_write_arbiter against a
// transaction-level reference model (owner index, clear phase, pending flag).
module tb_register_write_arbiter;
    localparam int BW = 32;
    localparam int N  = 4;
    localparam int TO = 15;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      req;
    logic [N-1:0]      last;
    logic [N*BW-1:0]   data;
    logic              clr;
    logic [N-1:0]      gnt;
    logic              busy;
    logic              en;
    logic              oclr;
    logic [BW-1:0]     odata;

    int checks = 0;
    int errors = 0;

    register_write_arbiter #(.BITWIDTH(BW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .iClk(clk), .iRstN(rstn), .iReq(req), .iLast(last), .iData(data),
        .iClr(clr), .oGnt(gnt), .oBusy(busy), .oEn(en), .oClr(oclr), .oData(odata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: -1 owner means nobody holds the register.
    int          m_owner;
    bit          m_clear;
    bit          m_pend;
    int          m_ptr;
    int          m_stall;
    logic [N-1:0]  e_gnt;
    logic          e_busy, e_en, e_clr;
    logic [BW-1:0] e_data;

    task automatic model_reset();
        m_owner = -1; m_clear = 0; m_pend = 0; m_ptr = 0; m_stall = 0;
        e_gnt = '0; e_busy = 0; e_en = 0; e_clr = 0; e_data = '0;
    endtask

    task automatic model_step();
        bit pend_after;
        pend_after = m_pend | clr;
        e_en = 0;
        e_clr = 0;
        if (m_clear) begin
            m_clear = 0;
        end else if (m_owner < 0) begin
            if (m_pend) begin
                m_clear = 1;
                e_clr = 1;
                pend_after = clr;
            end else if (req != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_stall = 0;
            end
        end else if (req[m_owner]) begin
            e_en = 1;
            e_data = data[m_owner*BW +: BW];
            m_stall = 0;
            if (last[m_owner]) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            m_stall++;
            if (TO != 0 && m_stall == TO) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
                m_stall = 0;
            end
        end
        m_pend = pend_after;
        e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_busy = (m_owner >= 0) || m_clear;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("gnt", 64'(gnt), 64'(e_gnt));
        check("busy", 64'(busy), 64'(e_busy));
        check("en", 64'(en), 64'(e_en));
        check("clr", 64'(oclr), 64'(e_clr));
        check("data", 64'(odata), 64'(e_data));
        if (en && oclr) check("en_clr_exclusive", 64'(en & oclr), 64'd0);
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are compared.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req = '0; last = '0; clr = 1'b0; data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        int en_count;
        rstn = 1'b0; req = '0; last = '0; data = '0; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", 64'(gnt), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data", 64'(odata), 64'd0);
        #3 rstn = 1'b1;
        #1;

        // Single 3-beat burst from requester 2.
        req = 4'b0100;
        data[2*BW +: BW] = 32'hA5;
        tick();
        check("t1_grant", 64'(gnt), 64'h4);
        en_count = 0;
        for (int b = 0; b < 3; b++) begin
            last = (b == 2) ? 4'b0100 : 4'b0000;
            tick();
            if (en) en_count++;
            check("t1_wdata", 64'(odata), 64'hA5);
        end
        req = '0; last = '0;
        tick();
        check("t1_en_count", 64'(en_count), 64'd3);
        check("t1_gnt_off", 64'(gnt), 64'd0);
        // ptr advanced to 3: all requesting picks requester 3.
        req = 4'b1111; last = 4'b1111;
        tick();
        check("t1_ptr3", 64'(gnt), 64'h8);
        tick();

        // Fairness rotation with single-beat bursts.
        do_reset();
        req = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("rr_gnt", 64'(gnt), (k % 2 == 0) ? 64'(1 << ((k / 2) % 4)) : 64'd0);
        end

        // Clear requested mid-burst waits for the burst end.
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0011;
        data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) begin
            tick();
            check("clr_deferred", 64'(oclr), 64'd0);
        end
        last = 4'b0010;
        tick();
        req = 4'b0001; last = '0;
        tick();
        check("clr_pulse", 64'(oclr), 64'd1);
        tick();
        check("clr_pulse_end", 64'(oclr), 64'd0);
        tick();
        check("clr_next_grant", 64'(gnt), 64'h1);

        // Timeout after a single beat.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        check("to_beat", 64'(en), 64'd1);
        req = 4'b0010;
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            check("to_hold", 64'(gnt), 64'h1);
        end
        tick();
        check("to_revoke", 64'(gnt), 64'd0);
        check("to_no_write", 64'(en), 64'd0);
        tick();
        check("to_next", 64'(gnt), 64'h2);

        // Asynchronous reset mid-burst.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        check("arst_pre_en", 64'(en), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_gnt", 64'(gnt), 64'd0);
        check("arst_en", 64'(en), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_data", 64'(odata), 64'd0);
        model_reset();
        req = '0;
        @(posedge clk);
        #3 rstn = 1'b1;
        req = 4'b1111;
        #1;
        tick();
        check("arst_first", 64'(gnt), 64'h1);

        // Clear re-requested on the cycle CLEAR is entered.
        do_reset();
        clr = 1'b1;
        tick();
        tick();
        check("dclr_p1", 64'(oclr), 64'd1);
        clr = 1'b0;
        tick();
        check("dclr_gap", 64'(oclr), 64'd0);
        tick();
        check("dclr_p2", 64'(oclr), 64'd1);
        tick();
        check("dclr_end", 64'(oclr), 64'd0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req  = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            last = N'($urandom) & N'($urandom);
            clr  = ($urandom_range(0, 19) == 0);
            data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Round-robin arbiter that shares one `register` instance between NUM_REQ write requesters. Each requester owns the register for a multi-beat burst, ending with iLast. The block drives the register's enable, clear and data inputs from registered outputs. It also sequences a global clear request between bursts and revokes ownership from a requester that stalls for too long.

## Interface
- BITWIDTH, 32, data width; matches the shared register.
- NUM_REQ, 4, number of requesters, 2..16.
- TIMEOUT, 15, consecutive stalled owner cycles before ownership is revoked; 0 disables the timeout.
- iClk  in  1  clock.
- iRstN  in  1  reset, asynchronous, active-low.
- iReq  in  NUM_REQ  per-requester valid; doubles as a request when not owner.
- iLast  in  NUM_REQ  per-requester last beat of burst; qualified by iReq and grant.
- iData  in  NUM_REQ*BITWIDTH  packed data; requester k occupies bits [k*BITWIDTH +: BITWIDTH].
- iClr  in  1  global clear request pulse.
- oGnt  out  NUM_REQ  one-hot grant; also the per-requester ready.
- oBusy  out  1  high when the state is not IDLE.
- oEn  out  1  write enable to the register.
- oClr  out  1  clear to the register.
- oData  out  BITWIDTH  write data to the register.

## Operation
- States: IDLE, OWN, CLEAR. Internal registers:
  - ptr, round-robin start index, clog2(NUM_REQ) bits, wraps modulo NUM_REQ.
  - owner index.
  - stall counter.
  - clrPend, sticky flag.
- clrPend is set by iClr in any state. It is cleared only when CLEAR is entered. If iClr is high in the same cycle that CLEAR is entered, the set wins and clrPend stays 1.
- IDLE, checked in priority order:
  - If clrPend is set, go to CLEAR.
  - Else if |iReq, pick the first asserted index searching ptr, ptr+1, … with wrap. Set owner to that index and oGnt to its one-hot, then go to OWN.
  - Else stay in IDLE.
- OWN:
  - A beat is a cycle with iReq[owner]=1. On a beat, register oEn=1 and oData=iData slice of owner, and reset the stall counter to 0.
  - Beat with iLast[owner]=1: go to IDLE, set oGnt=0, set ptr=(owner+1) mod NUM_REQ.
  - No beat: oEn=0 and the stall counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0), go to IDLE with the same ptr update and oGnt=0. No write occurs.
  - iLast without iReq is ignored.
  - Requests and iLast from non-owners are ignored.
  - clrPend does not pre-empt an active burst.
- CLEAR: oClr=1 for exactly one cycle, then go to IDLE. ptr is unchanged.
- oData holds its last value whenever oEn=0.
- oEn and oClr are never high in the same cycle.
- Asserting iRstN low at any time, including mid-burst or in CLEAR, forces the reset values below immediately.

## Timing
- All outputs are registered. Reset values:
  - state=IDLE.
  - oGnt=0, oBusy=0, oEn=0, oClr=0, oData=0.
  - ptr=0, clrPend=0, stall counter=0.
- Grant latency: iReq sampled in IDLE at edge e gives oGnt and oBusy high after e.
- Write latency: a beat accepted at edge e gives oEn/oData valid after e. The register captures at edge e+1.
- One IDLE bubble between consecutive bursts: the burst ending at edge e is followed by a new grant after edge e+1.
- Clear latency: iClr in IDLE at edge e gives oClr high after edge e+1 (CLEAR entered at e+1), low again after e+2.
- Timeout: grant at edge g with no beats gives oGnt=0 after edge g+TIMEOUT.

## Test plan
- Reset, then iReq=4'b0100, iData slice2=0xA5, iLast[2] on the 3rd beat:
  - oGnt=0100 one cycle after the request.
  - oEn=1 for exactly 3 cycles with oData=0xA5.
  - Then oGnt=0 and ptr=3.
- Fairness: iReq=4'b1111 held, each burst a single beat with iLast → grants rotate 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- iClr pulse mid-burst of requester 1 → oClr stays 0 until requester 1's iLast, then oClr=1 for one cycle, then the next grant.
- TIMEOUT=15, owner drops iReq after 1 beat → oGnt cleared exactly 15 cycles after the last beat, oEn stays 0, and the next requester is granted.
- iRstN asserted mid-burst with oEn=1 → all outputs 0 immediately, and after release the first grant starts the search at index 0.
- iClr in the same cycle CLEAR is entered → two oClr pulses separated by one IDLE cycle.
